dmem_arbiter: RTL

Two-requester arbiter sharing the single-port data memory between the single-cycle core and an external master (debug/DMA loader). It sits between the core's load/store datapath and the data memory. It grants at most one access per cycle and stalls the core when the external master holds the port. The external master is guaranteed bounded wait and may lock the port for short atomic bursts.

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core and an
// external master. The core normally wins. The external master wins when the
// core is idle, after MAX_WAIT lost cycles, or while a lock is held. A lock
// holds for at most MAX_BURST consecutive grants.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_rvalid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              lock_q, lock_d;
    logic [DATA_W-1:0] e_rdata_q, e_rdata_d;
    logic              e_rvalid_q, e_rvalid_d;
    logic              locked;
    logic              e_rd_gnt;

    // Grant decision and memory port mux; reset blocks any grant or write.
    always_comb begin
        locked  = lock_q & (burst_cnt_q < BURST_MAX);
        e_gnt   = ~reset & e_req & (~c_req | (wait_cnt_q == WAIT_MAX) | locked);
        c_stall = c_req & e_gnt;
        c_rdata = m_rdata;
        if (e_gnt) begin
            m_addr  = e_addr;
            m_wdata = e_wdata;
            m_we    = e_we;
        end else begin
            m_addr  = c_addr;
            m_wdata = c_wdata;
            m_we    = ~reset & c_req & c_we;
        end
    end

    // Next-state: starvation counter, burst counter, lock and external read capture.
    always_comb begin
        e_rd_gnt = e_gnt & ~e_we;

        wait_cnt_d = wait_cnt_q;
        if (e_gnt | ~e_req) begin
            wait_cnt_d = '0;
        end else if (c_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end

        burst_cnt_d = '0;
        if (e_gnt) begin
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + BW'(1);
        end

        lock_d     = e_gnt & e_lock;
        e_rvalid_d = e_rd_gnt;
        e_rdata_d  = e_rd_gnt ? m_rdata : e_rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            lock_q      <= 1'b0;
            e_rdata_q   <= '0;
            e_rvalid_q  <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            lock_q      <= lock_d;
            e_rdata_q   <= e_rdata_d;
            e_rvalid_q  <= e_rvalid_d;
        end
    end

    assign e_rdata  = e_rdata_q;
    assign e_rvalid = e_rvalid_q;

endmodule
